// File: rtl/lcd12864_bus_sched.sv
// Write scheduler for the 12864 LCD parallel bus. It runs the power-on init
// sequence, then arbitrates round-robin between two single-byte requesters.
// Each requester uses a valid/ready handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RST_LO   | LCD_RST held low after reset
// POR_WAIT | LCD_RST released, waiting before the first init write
// LOAD     | pick the next init byte (init sequence only)
// SETUP    | rs/dat driven, en low
// EN_HI    | en high
// HOLD     | en low again, rs/dat still held
// WAIT     | LCD busy time (long after clear/home commands)
// ARB      | idle, grant one pending requester
module lcd12864_bus_sched #(
    parameter int SETUP_CYC    = 4,
    parameter int EN_HIGH_CYC  = 25,
    parameter int HOLD_CYC     = 4,
    parameter int CMD_WAIT_CYC = 4000,
    parameter int CLR_WAIT_CYC = 80000,
    parameter int RST_CYC      = 500000,
    parameter int POR_WAIT_CYC = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_dat,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_dat,
    output logic       req1_ready,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dat,
    output logic       LCD_RST,
    output logic       PSB,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        RST_LO, POR_WAIT, LOAD, SETUP, EN_HI, HOLD, WAIT, ARB
    } state_t;

    localparam int CW = 22;
    localparam logic [CW-1:0] RST_LD   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] POR_LD   = CW'(POR_WAIT_CYC - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT_CYC - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    init_idx, init_idx_nx;
    logic          init_done_nx;
    logic          ptr, ptr_nx;
    logic          rs_nx;
    logic [7:0]    dat_nx;
    logic          cnt_zero;
    logic          is_clr;
    logic          gnt0, gnt1;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h30;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign cnt_zero = (cnt == '0);
    // Clear and home commands need the long busy wait.
    assign is_clr   = !rs && (dat == 8'h01 || dat == 8'h02);

    // Pointer only breaks ties; a lone valid requester is always granted.
    assign gnt0 = (state == ARB) && req0_valid && (!ptr || !req1_valid);
    assign gnt1 = (state == ARB) && req1_valid && (ptr || !req0_valid);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign en         = (state == EN_HI);
    assign LCD_RST    = (state != RST_LO);
    assign busy       = (state != ARB);
    assign rw         = 1'b0;
    assign PSB        = 1'b1;

    // State register, timer, latched bus byte and bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_LO;
            cnt       <= RST_LD;
            init_idx  <= 2'd0;
            init_done <= 1'b0;
            ptr       <= 1'b0;
            rs        <= 1'b0;
            dat       <= 8'h00;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            init_idx  <= init_idx_nx;
            init_done <= init_done_nx;
            ptr       <= ptr_nx;
            rs        <= rs_nx;
            dat       <= dat_nx;
        end
    end

    // Next-state logic; the timer is reloaded with N-1 on every state entry.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt_zero ? cnt : cnt - CW'(1);
        init_idx_nx  = init_idx;
        init_done_nx = init_done;
        ptr_nx       = ptr;
        rs_nx        = rs;
        dat_nx       = dat;
        case (state)
            RST_LO: if (cnt_zero) begin
                state_nx = POR_WAIT;
                cnt_nx   = POR_LD;
            end
            POR_WAIT: if (cnt_zero) begin
                state_nx = LOAD;
            end
            LOAD: begin
                state_nx = SETUP;
                cnt_nx   = SETUP_LD;
                rs_nx    = 1'b0;
                dat_nx   = init_byte(init_idx);
            end
            SETUP: if (cnt_zero) begin
                state_nx = EN_HI;
                cnt_nx   = EN_LD;
            end
            EN_HI: if (cnt_zero) begin
                state_nx = HOLD;
                cnt_nx   = HOLD_LD;
            end
            HOLD: if (cnt_zero) begin
                state_nx = WAIT;
                cnt_nx   = is_clr ? CLR_LD : CMD_LD;
            end
            WAIT: if (cnt_zero) begin
                if (init_done) begin
                    state_nx = ARB;
                end else if (init_idx == 2'd3) begin
                    state_nx     = ARB;
                    init_done_nx = 1'b1;
                end else begin
                    state_nx    = LOAD;
                    init_idx_nx = init_idx + 2'd1;
                end
            end
            ARB: begin
                if (gnt0) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                    rs_nx    = req0_rs;
                    dat_nx   = req0_dat;
                    ptr_nx   = 1'b1;
                end else if (gnt1) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                    rs_nx    = req1_rs;
                    dat_nx   = req1_dat;
                    ptr_nx   = 1'b0;
                end
            end
            default: state_nx = RST_LO;
        endcase
    end

endmodule

// File: doc/lcd12864_bus_sched.md
# lcd12864_bus_sched

Write scheduler for the 12864 character LCD parallel bus. Runs the power-on init sequence, then arbitrates between two requesters (binary/bit display and decimal display) for single-byte LCD writes. Generates the rs/rw/en/dat timing, including the long busy wait after clear/home commands. Replaces free-running per-character state stepping with an explicit valid/ready handshake per byte.

## Interface
Parameters (cycle counts; every value must be ≥1):
- SETUP_CYC, 4, cycles rs/dat stable before en rises
- EN_HIGH_CYC, 25, en high width
- HOLD_CYC, 4, rs/dat held after en falls
- CMD_WAIT_CYC, 4000, post-write busy wait for normal command/data
- CLR_WAIT_CYC, 80000, post-write busy wait for command 0x01 or 0x02
- RST_CYC, 500000, LCD_RST low time after reset
- POR_WAIT_CYC, 2500000, wait after LCD_RST release before first init write

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester k has a byte pending
- req0_rs / req1_rs  in  1  0 = command, 1 = data
- req0_dat / req1_dat  in  8  byte to write
- req0_ready / req1_ready  out  1  byte accepted this cycle when valid also high
- rs, rw, en  out  1  LCD control
- dat  out  8  LCD data bus
- LCD_RST  out  1  LCD reset, active low
- PSB  out  1  constant 1 (parallel mode)
- init_done  out  1  init sequence complete, sticky until reset
- busy  out  1  high in every state except ARB

## Operation
- States: RST_LO, POR_WAIT, LOAD, SETUP, EN_HI, HOLD, WAIT, ARB.
- RST_LO: LCD_RST=0 for RST_CYC cycles -> POR_WAIT (LCD_RST=1) for POR_WAIT_CYC -> LOAD.
- LOAD (init only): latches init byte i (0x30, 0x0C, 0x01, 0x06; rs=0) -> SETUP.
- SETUP (SETUP_CYC, en=0) -> EN_HI (EN_HIGH_CYC, en=1) -> HOLD (HOLD_CYC, en=0) -> WAIT.
- WAIT: CLR_WAIT_CYC if latched rs=0 and dat is 0x01 or 0x02, else CMD_WAIT_CYC. Then LOAD if init bytes remain; after the 4th init byte, set init_done and go to ARB.
- ARB: if neither valid, stay. Otherwise grant one requester: readyk=1 combinationally for that requester only. On that edge latch reqk_rs/reqk_dat into rs/dat, go to SETUP.
- Round-robin: pointer names the preferred requester. After granting k, pointer points to the other requester. Pointer resets to requester 0.
- rw is constant 0. dat and rs change only on entry to SETUP (latch edge). They hold through WAIT and ARB.
- Requests during init are never acknowledged; ready stays 0 outside ARB.
- A requester may drop valid before ready; nothing is written.
- Counters: one 22-bit down-counter loaded with N-1 on state entry; state exits when it reads 0.

## Timing
- Reset values (async, immediate): LCD_RST=0, en=0, rw=0, rs=0, dat=0x00, PSB=1, ready0=ready1=0, init_done=0, busy=1, state RST_LO, pointer=0, init index=0.
- Reset mid-write drops en in the same instant and restarts the full init sequence.
- Per write, accept edge to en rise = SETUP_CYC cycles. en high = EN_HIGH_CYC cycles. en fall to ARB = HOLD_CYC + wait cycles.
- Minimum spacing between accepts: SETUP+EN_HIGH+HOLD+wait+1 cycles (ARB lasts at least 1 cycle).
- init_done rises on the edge leaving the final WAIT, together with entry to ARB. The first readyk is possible that same cycle.
- Simultaneous valids: exactly one ready is high, the one named by the pointer.

## Test plan
(Bench overrides: RST_CYC=3, POR_WAIT_CYC=5, SETUP=2, EN_HIGH=3, HOLD=2, CMD_WAIT=6, CLR_WAIT=20.)
- Reset release, no requests -> LCD_RST low 3 cycles; en pulses carry 0x30, 0x0C, 0x01, 0x06 with rs=0, each en high exactly 3 cycles; gap after 0x01 is 20 wait cycles; init_done=1 after the 4th wait.
- req0_valid held during init -> req0_ready stays 0 until init_done. Then one accept; rs=1, dat=req0_dat on the en pulse.
- Both valid continuously, req0 0x41/rs=1, req1 0x42/rs=1 -> accepts alternate 0,1,0,1. Accepts are spaced exactly 2+3+2+6+1=14 cycles.
- req1 sends cmd 0x01 rs=0 -> next accept no earlier than 2+3+2+20+1=28 cycles later. Cmd 0x80 -> 14 cycles.
- rst_n asserted during EN_HI -> en, ready, init_done=0 immediately, LCD_RST=0. After release, the full init sequence repeats.
- req0_valid pulsed for 1 cycle while in WAIT -> no ready, no write. Bus rs/dat unchanged.
